// File: rtl/music_seq_player.sv
// Tone sequencer for a passive buzzer. Walks an external synchronous
// note/duration ROM, plays each note for dur x UNIT_CYCLES clocks with a
// volume-scaled duty cycle, and supports loop, pause, stop and an
// end-of-song marker (duration 0).
//
// Control handshake: start and stop are single-cycle request pulses with no
// ready. start is accepted only while busy is low. stop is always accepted
// and wins over everything but rst. done is a one-cycle completion strobe,
// never raised by stop. ROM reads have one cycle of latency: rom_period and
// rom_dur always belong to the rom_addr of the previous cycle.
module music_seq_player #(
    parameter int CLK_FRE     = 50,
    parameter int UNIT_CYCLES = CLK_FRE * 1000000 / 8,
    parameter int ADDR_W      = 9,
    parameter int PERIOD_W    = 20,
    parameter int DUR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                loop_en,
    input  logic [2:0]          vol,
    input  logic [ADDR_W-1:0]   song_len,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PERIOD_W-1:0] rom_period,
    input  logic [DUR_W-1:0]    rom_dur,
    output logic                buzzer,
    output logic                busy,
    output logic                paused,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [PERIOD_W-1:0] per_q;
    logic [PERIOD_W-1:0] ph_q;
    logic [PERIOD_W-1:0] on_time;
    logic [DUR_W-1:0]    dur_q;
    logic [DUR_W-1:0]    dur_cnt_q;
    logic [UNIT_W-1:0]   unit_cnt_q;
    logic [2:0]          vol_q;
    logic                note_last;
    logic                song_last;
    logic                advance;

    // Last cycle of the note: both the unit and duration counters at their top.
    assign note_last = (unit_cnt_q == UNIT_LAST) && (dur_cnt_q == dur_q - DUR_W'(1));
    assign song_last = (rom_addr == song_len - ADDR_W'(1));
    // Volume 7 gives per/4, volume 1 gives per/256.
    assign on_time   = per_q >> (4'd9 - {1'b0, vol_q});

    assign busy   = (state_q != S_IDLE);
    assign paused = (state_q == S_PAUSED);
    assign done   = (state_q == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; advance marks a PLAY cycle that moves the counters on.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (song_len != '0)) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                state_d = (rom_dur == '0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                // A pause arriving on the final cycle lets the note finish first.
                if (!pause || note_last) begin
                    advance = 1'b1;
                    if (note_last) begin
                        state_d = (song_last && !loop_en) ? S_DONE : S_FETCH;
                    end
                end else begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause) state_d = S_PLAY;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            advance = 1'b0;
        end
    end

    // Note latches, unit/duration/tone counters, ROM address and buzzer drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            per_q      <= '0;
            dur_q      <= '0;
            vol_q      <= '0;
            ph_q       <= '0;
            unit_cnt_q <= '0;
            dur_cnt_q  <= '0;
            buzzer     <= 1'b1;
        end else begin
            // Drive low only on a counted PLAY cycle inside the on-time window.
            buzzer <= ~(advance && (vol_q != 3'd0) && (per_q != '0) && (ph_q < on_time));
            if (stop) begin
                rom_addr <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        per_q      <= rom_period;
                        dur_q      <= rom_dur;
                        vol_q      <= vol;
                        ph_q       <= '0;
                        unit_cnt_q <= '0;
                        dur_cnt_q  <= '0;
                    end
                    S_PLAY: begin
                        if (advance) begin
                            if ((per_q == '0) || (ph_q == per_q - PERIOD_W'(1))) begin
                                ph_q <= '0;
                            end else begin
                                ph_q <= ph_q + PERIOD_W'(1);
                            end
                            if (unit_cnt_q == UNIT_LAST) begin
                                unit_cnt_q <= '0;
                                dur_cnt_q  <= dur_cnt_q + DUR_W'(1);
                            end else begin
                                unit_cnt_q <= unit_cnt_q + UNIT_W'(1);
                            end
                            if (state_d == S_FETCH) begin
                                rom_addr <= song_last ? '0 : rom_addr + ADDR_W'(1);
                            end
                        end
                    end
                    S_DONE:  rom_addr <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_seq_player.sv
// Bench for music_seq_player. Each scenario is a per-cycle input table; a
// behavioural model walks the song note by note from those tables and
// produces the expected output trace, which a monitor compares cycle by cycle.
module tb_music_seq_player;

  localparam int ADDR_W = 9;
  localparam int PERIOD_W = 20;
  localparam int DUR_W = 8;
  localparam int UNIT = 10;
  localparam int W = ADDR_W + 4;
  localparam int MAXC = 400;

  typedef struct {
    int exp_done;
    int exp_low;
  } ck_t;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic pause;
  logic loop_en;
  logic [2:0] vol;
  logic [ADDR_W-1:0] song_len;
  logic [ADDR_W-1:0] rom_addr;
  logic [PERIOD_W-1:0] rom_period;
  logic [DUR_W-1:0] rom_dur;
  logic buzzer;
  logic busy;
  logic paused;
  logic done;

  logic [PERIOD_W-1:0] mem_per [0:511];
  logic [DUR_W-1:0] mem_dur [0:511];

  logic start_a [MAXC];
  logic stop_a [MAXC];
  logic pause_a [MAXC];
  logic loop_a [MAXC];
  logic [2:0] vol_a [MAXC];
  int len_cfg;

  int ex_addr [MAXC];
  logic ex_busy [MAXC];
  logic ex_paused [MAXC];
  logic ex_done [MAXC];
  logic bz_next [MAXC];
  int model_done;
  int model_low;
  int cur_n;

  logic [W-1:0] exp_q[$];
  ck_t ck_q[$];
  int checks;
  int errors;
  int obs_done;
  int obs_low;

  music_seq_player #(
    .UNIT_CYCLES(UNIT),
    .ADDR_W(ADDR_W),
    .PERIOD_W(PERIOD_W),
    .DUR_W(DUR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .vol(vol),
    .song_len(song_len),
    .rom_addr(rom_addr),
    .rom_period(rom_period),
    .rom_dur(rom_dur),
    .buzzer(buzzer),
    .busy(busy),
    .paused(paused),
    .done(done)
  );

  // ---------------- clock / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_period <= mem_per[rom_addr];
    rom_dur <= mem_dur[rom_addr];
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    ck_t ck;
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      act_w = {buzzer, busy, paused, done, rom_addr};
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL trace t=%0t got bz=%b busy=%b paused=%b done=%b addr=%0d expected bz=%b busy=%b paused=%b done=%b addr=%0d",
                 $time, act_w[W-1], act_w[W-2], act_w[W-3], act_w[W-4], act_w[ADDR_W-1:0],
                 exp_w[W-1], exp_w[W-2], exp_w[W-3], exp_w[W-4], exp_w[ADDR_W-1:0]);
      end
      if (done === 1'b1) obs_done++;
      if (buzzer === 1'b0) obs_low++;
    end else if (ck_q.size() != 0) begin
      ck = ck_q.pop_front();
      checks++;
      if (obs_done != ck.exp_done) begin
        errors++;
        $display("FAIL done_count got %0d expected %0d", obs_done, ck.exp_done);
      end
      checks++;
      if (obs_low != ck.exp_low) begin
        errors++;
        $display("FAIL buzzer_low_count got %0d expected %0d", obs_low, ck.exp_low);
      end
      obs_done = 0;
      obs_low = 0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic tone_bz(input int k, input int per, input int v);
    int on_t;
    if (v == 0 || per == 0) return 1'b1;
    on_t = per / (1 << (9 - v));
    return !((k % per) < on_t);
  endfunction

  task automatic mark(input int c, input int a, input logic p, input logic d);
    if (c < cur_n) begin
      ex_addr[c] = a;
      ex_busy[c] = 1'b1;
      ex_paused[c] = p;
      ex_done[c] = d;
    end
  endtask

  // Walk the song: idle until an accepted start, then for every note one
  // fetch cycle, one load cycle and dur*UNIT counted play cycles, with
  // pauses inserted and stop aborting wherever the input tables say so.
  task automatic build_expected(input int n);
    int c, a, k, total, per, dur, v;
    logic stopped, lp;
    cur_n = n;
    for (int i = 0; i < MAXC; i++) begin
      ex_addr[i] = 0; ex_busy[i] = 0; ex_paused[i] = 0; ex_done[i] = 0; bz_next[i] = 1;
    end
    c = 0;
    while (c < n) begin
      if (start_a[c] && !stop_a[c] && len_cfg != 0) begin
        c++; a = 0; stopped = 0;
        while (!stopped && c < n) begin
          mark(c, a, 0, 0);
          if (stop_a[c]) begin c++; break; end
          c++;
          if (c >= n) break;
          mark(c, a, 0, 0);
          if (stop_a[c]) begin c++; break; end
          per = int'(mem_per[a]); dur = int'(mem_dur[a]); v = int'(vol_a[c]);
          c++;
          if (dur == 0) begin mark(c, a, 0, 1); c++; break; end
          total = dur * UNIT; k = 0; lp = 0;
          while (k < total && !stopped && c < n) begin
            mark(c, a, 0, 0);
            if (stop_a[c]) begin
              stopped = 1; c++;
            end else if (pause_a[c] && k != total - 1) begin
              c++;
              while (c < n) begin
                mark(c, a, 1, 0);
                if (stop_a[c]) begin stopped = 1; c++; break; end
                c++;
                if (!pause_a[c-1]) break;
              end
            end else begin
              bz_next[c] = tone_bz(k, per, v); lp = loop_a[c]; k++; c++;
            end
          end
          if (stopped || k < total) break;
          if (a == len_cfg - 1) begin
            if (lp) a = 0;
            else begin mark(c, a, 0, 1); c++; break; end
          end else begin
            a++;
          end
        end
      end else begin
        c++;
      end
    end
    model_done = 0;
    model_low = 0;
    for (int i = 0; i < n; i++) begin
      if (ex_done[i]) model_done++;
      if (i > 0 && !bz_next[i-1]) model_low++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_a[i] = 0; stop_a[i] = 0; pause_a[i] = 0; loop_a[i] = 0; vol_a[i] = 3'd7;
    end
  endtask

  task automatic load_song1();
    mem_per[0] = 20'd8;  mem_dur[0] = 8'd2;
    mem_per[1] = 20'd0;  mem_dur[1] = 8'd1;
    mem_per[2] = 20'd16; mem_dur[2] = 8'd1;
  endtask

  // Entered just after a rising edge; leaves the DUT idle just after a rising edge.
  task automatic run_scn(input int n, input int exp_done, input int exp_low);
    ck_t ck;
    song_len = ADDR_W'(len_cfg);
    build_expected(n);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back({(c == 0) ? 1'b1 : bz_next[c-1], ex_busy[c], ex_paused[c], ex_done[c],
                       ADDR_W'(ex_addr[c])});
    end
    for (int c = 0; c < n; c++) begin
      start = start_a[c]; stop = stop_a[c]; pause = pause_a[c];
      loop_en = loop_a[c]; vol = vol_a[c];
      @(posedge clk); #1;
    end
    start = 0; pause = 0; loop_en = 0; stop = 1;
    @(posedge clk); #1;
    stop = 0;
    ck.exp_done = (exp_done < 0) ? model_done : exp_done;
    ck.exp_low = (exp_low < 0) ? model_low : exp_low;
    ck_q.push_back(ck);
    @(posedge clk); #1;
  endtask

  task automatic gen_random(input int n);
    logic p, l;
    len_cfg = $urandom_range(1, 5);
    for (int i = 0; i < 8; i++) begin
      mem_per[i] = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(3, 40));
      mem_dur[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
    end
    p = 0;
    l = 1'($urandom_range(0, 1));
    for (int c = 0; c < n; c++) begin
      start_a[c] = (c == 2) || ($urandom_range(0, 29) == 0);
      stop_a[c] = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 11) == 0) p = !p;
      pause_a[c] = p;
      if ($urandom_range(0, 39) == 0) l = !l;
      loop_a[c] = l;
      vol_a[c] = 3'($urandom_range(0, 7));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; errors = 0; obs_done = 0; obs_low = 0;
    for (int i = 0; i < 512; i++) begin mem_per[i] = '0; mem_dur[i] = '0; end
    rst = 1; start = 0; stop = 0; pause = 0; loop_en = 0; vol = 3'd7; song_len = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(0)});
    rst = 0;
    @(posedge clk); #1;

    // Three-note song, single pass.
    clear_stim(); load_song1(); len_cfg = 3; start_a[2] = 1;
    run_scn(60, 1, 10);

    // Loop mode, loop_en cleared during the second pass.
    clear_stim(); load_song1(); len_cfg = 3; start_a[2] = 1;
    for (int c = 0; c < 70; c++) loop_a[c] = 1;
    run_scn(110, 1, 20);

    // 25-cycle pause inside a single 20-cycle note.
    clear_stim(); mem_per[0] = 20'd8; mem_dur[0] = 8'd2; len_cfg = 1; start_a[2] = 1;
    for (int c = 10; c < 35; c++) pause_a[c] = 1;
    run_scn(60, 1, 6);

    // Stop mid-note, then start and stop together while idle.
    clear_stim(); load_song1(); len_cfg = 3; start_a[2] = 1; stop_a[15] = 1;
    start_a[40] = 1; stop_a[40] = 1;
    run_scn(50, 0, 4);

    // End-of-song marker at address 1.
    clear_stim(); load_song1(); mem_per[1] = 20'd5; mem_dur[1] = 8'd0; len_cfg = 3; start_a[2] = 1;
    run_scn(40, 1, 6);

    // Empty song length: start ignored.
    clear_stim(); len_cfg = 0; start_a[2] = 1;
    run_scn(10, 0, 0);

    // Volume 0: silent but still completes.
    clear_stim(); load_song1(); len_cfg = 3; start_a[2] = 1;
    for (int c = 0; c < MAXC; c++) vol_a[c] = 3'd0;
    run_scn(60, 1, 0);

    // Randomised scenarios against the model.
    for (int s = 0; s < 8; s++) begin
      clear_stim(); gen_random(250);
      run_scn(250, -1, -1);
    end

    // Reset in the middle of a note.
    load_song1(); song_len = ADDR_W'(3); vol = 3'd7;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(0)});
    rst = 0;
    repeat (4) @(posedge clk);
    #1;

    if (exp_q.size() != 0 || ck_q.size() != 0) begin
      $display("FAIL drain pending=%0d expected 0", exp_q.size() + ck_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
